// File: rtl/updtxq_pkg.sv
// updtxq shared types: FSM states, completion status codes, PHY FIFO ACK codes.
package updtxq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TXWAIT,
        S_CRCWAIT,
        S_RETRY,
        S_DONE
    } state_t;

    localparam logic [1:0] STA_OK      = 2'd0;
    localparam logic [1:0] STA_NOGDCRC = 2'd1;
    localparam logic [1:0] STA_ABORT   = 2'd2;
    localparam logic [1:0] STA_ERR     = 2'd3;

    localparam logic [1:0] FF_ACK = 2'd1;
    localparam logic [1:0] FF_NAK = 2'd2;

endpackage

// File: rtl/updtxq_tmr.sv
// GoodCRC wait timer: loadable down-counter; zero pulses on the cycle
// the count steps from 1 to 0.
module updtxq_tmr #(
    parameter int TMR_NBT = 10
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               load,
    input  logic [TMR_NBT-1:0] ldval,
    input  logic               dec,
    output logic               zero
);

    logic [TMR_NBT-1:0] cnt;

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= ldval;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - TMR_NBT'(1);
        end
    end

    assign zero = dec && (cnt == TMR_NBT'(1));

endmodule

// File: rtl/updtxq.sv
// USBPD TX message queue with GoodCRC retry control.
// Build option: UPDTXQ_RXABORT_EN makes i_rxact abort LOAD/TXWAIT/RETRY.
module updtxq
    import updtxq_pkg::*;
#(
    parameter int MAX_LEN   = 30,
    parameter int LEN_NBT   = 5,
    parameter int RETRY_MAX = 2,
    parameter int CRC_TMO   = 900,
    parameter int TMR_NBT   = 10
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               i_start,
    input  logic [LEN_NBT-1:0] i_len,
    input  logic               i_abort,
    output logic [LEN_NBT-1:0] o_badr,
    input  logic [7:0]         i_bdat,
    output logic               o_busy,
    output logic               o_done,
    output logic [1:0]         o_sta,
    output logic [1:0]         o_rtycnt,
    output logic               o_fifopsh,
    output logic [7:0]         o_wdat,
    output logic               o_first,
    output logic               o_last,
    output logic               o_fiforst,
    input  logic [1:0]         i_ffack,
    input  logic               i_fffull,
    input  logic               i_txack,
    input  logic               i_gdcrc,
    input  logic               i_ccidle,
    input  logic               i_rxact
);

    localparam logic [TMR_NBT-1:0] TMO_LD  = TMR_NBT'(CRC_TMO);
    localparam logic [LEN_NBT-1:0] LEN_MAX = LEN_NBT'(MAX_LEN);
    localparam logic [1:0]         RTY_MAX = 2'(RETRY_MAX);

    state_t             state, state_nxt;
    logic [LEN_NBT-1:0] len_q, len_nxt;
    logic [LEN_NBT-1:0] badr_q, badr_nxt;
    logic [1:0]         rty_q, rty_nxt;
    logic [1:0]         sta_q, sta_nxt;
    logic [1:0]         rtyo_q, rtyo_nxt;
    logic               frst_q, frst_nxt;
    logic               abort, nak, push, tmr_ld, tmr_zero;
    logic               fin;
    logic [1:0]         fin_sta;

`ifdef UPDTXQ_RXABORT_EN
    assign abort = i_abort
                || (i_rxact && (state == S_LOAD
                             || state == S_TXWAIT
                             || state == S_RETRY));
`else
    logic unused_rxact;
    assign unused_rxact = i_rxact;
    assign abort = i_abort;
`endif

    assign nak = (i_ffack == FF_NAK);

    updtxq_tmr #(
        .TMR_NBT (TMR_NBT)
    ) u_tmr (
        .clk   (clk),
        .srst  (srst),
        .load  (tmr_ld),
        .ldval (TMO_LD),
        .dec   (state == S_CRCWAIT),
        .zero  (tmr_zero)
    );

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state  <= S_IDLE;
            len_q  <= '0;
            badr_q <= '0;
            rty_q  <= '0;
            sta_q  <= STA_OK;
            rtyo_q <= '0;
            frst_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            len_q  <= len_nxt;
            badr_q <= badr_nxt;
            rty_q  <= rty_nxt;
            sta_q  <= sta_nxt;
            rtyo_q <= rtyo_nxt;
            frst_q <= frst_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        len_nxt   = len_q;
        badr_nxt  = badr_q;
        rty_nxt   = rty_q;
        sta_nxt   = sta_q;
        rtyo_nxt  = rtyo_q;
        frst_nxt  = 1'b0;
        push      = 1'b0;
        tmr_ld    = 1'b0;
        fin       = 1'b0;
        fin_sta   = STA_OK;
        unique case (state)
            S_IDLE: begin
                if (i_start) begin
                    rty_nxt = '0;
                    if (i_len == '0 || i_len > LEN_MAX) begin
                        fin     = 1'b1;
                        fin_sta = STA_ERR;
                    end else begin
                        len_nxt   = i_len;
                        badr_nxt  = '0;
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (abort) begin
                    fin      = 1'b1;
                    fin_sta  = STA_ABORT;
                    frst_nxt = 1'b1;
                end else if (nak) begin
                    fin      = 1'b1;
                    fin_sta  = STA_ERR;
                    frst_nxt = 1'b1;
                end else if (!i_fffull) begin
                    push = 1'b1;
                    if (badr_q == len_q - LEN_NBT'(1)) begin
                        state_nxt = S_TXWAIT;
                    end else begin
                        badr_nxt = badr_q + LEN_NBT'(1);
                    end
                end
            end
            S_TXWAIT: begin
                if (abort) begin
                    fin      = 1'b1;
                    fin_sta  = STA_ABORT;
                    frst_nxt = 1'b1;
                end else if (nak) begin
                    fin      = 1'b1;
                    fin_sta  = STA_ERR;
                    frst_nxt = 1'b1;
                end else if (i_txack) begin
                    tmr_ld    = 1'b1;
                    state_nxt = S_CRCWAIT;
                end
            end
            S_CRCWAIT: begin
                if (abort) begin
                    fin      = 1'b1;
                    fin_sta  = STA_ABORT;
                    frst_nxt = 1'b1;
                end else if (i_gdcrc) begin
                    fin     = 1'b1;
                    fin_sta = STA_OK;
                end else if (tmr_zero) begin
                    if (rty_q < RTY_MAX) begin
                        rty_nxt   = rty_q + 2'd1;
                        frst_nxt  = 1'b1;
                        state_nxt = S_RETRY;
                    end else begin
                        fin     = 1'b1;
                        fin_sta = STA_NOGDCRC;
                    end
                end
            end
            S_RETRY: begin
                if (abort) begin
                    fin      = 1'b1;
                    fin_sta  = STA_ABORT;
                    frst_nxt = 1'b1;
                end else if (i_ccidle) begin
                    badr_nxt  = '0;
                    state_nxt = S_LOAD;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // Status and retry count latch together on every completion.
        if (fin) begin
            state_nxt = S_DONE;
            sta_nxt   = fin_sta;
            rtyo_nxt  = rty_nxt;
        end
    end

    assign o_badr    = badr_q;
    assign o_busy    = (state == S_LOAD) || (state == S_TXWAIT)
                    || (state == S_CRCWAIT) || (state == S_RETRY);
    assign o_done    = (state == S_DONE);
    assign o_sta     = sta_q;
    assign o_rtycnt  = rtyo_q;
    assign o_fifopsh = push;
    assign o_wdat    = push ? i_bdat : 8'h00;
    assign o_first   = push && (badr_q == '0);
    assign o_last    = push && (badr_q == len_q - LEN_NBT'(1));
    assign o_fiforst = frst_q;

endmodule

// File: tb/tb_updtxq.sv
// Directed bench for updtxq: framing, stalls, retries, abort, length errors.
module tb_updtxq;

    logic       clk = 1'b0;
    logic       srst;
    logic       i_start;
    logic [4:0] i_len;
    logic       i_abort;
    logic [4:0] o_badr;
    logic [7:0] i_bdat;
    logic       o_busy;
    logic       o_done;
    logic [1:0] o_sta;
    logic [1:0] o_rtycnt;
    logic       o_fifopsh;
    logic [7:0] o_wdat;
    logic       o_first;
    logic       o_last;
    logic       o_fiforst;
    logic [1:0] i_ffack;
    logic       i_fffull;
    logic       i_txack;
    logic       i_gdcrc;
    logic       i_ccidle;
    logic       i_rxact;

    logic [7:0] mem [0:31];
    logic [7:0] plog [$];
    int         nfrst;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    assign i_bdat = mem[o_badr];

    updtxq dut (
        .clk       (clk),
        .srst      (srst),
        .i_start   (i_start),
        .i_len     (i_len),
        .i_abort   (i_abort),
        .o_badr    (o_badr),
        .i_bdat    (i_bdat),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_sta     (o_sta),
        .o_rtycnt  (o_rtycnt),
        .o_fifopsh (o_fifopsh),
        .o_wdat    (o_wdat),
        .o_first   (o_first),
        .o_last    (o_last),
        .o_fiforst (o_fiforst),
        .i_ffack   (i_ffack),
        .i_fffull  (i_fffull),
        .i_txack   (i_txack),
        .i_gdcrc   (i_gdcrc),
        .i_ccidle  (i_ccidle),
        .i_rxact   (i_rxact)
    );

    always @(negedge clk) begin
        if (o_fifopsh) plog.push_back(o_wdat);
        if (o_fiforst) nfrst++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        srst     = 1'b1;
        i_start  = 1'b0;
        i_len    = '0;
        i_abort  = 1'b0;
        i_ffack  = 2'd1;
        i_fffull = 1'b0;
        i_txack  = 1'b0;
        i_gdcrc  = 1'b0;
        i_ccidle = 1'b1;
        i_rxact  = 1'b0;
        nfrst    = 0;
        for (int k = 0; k < 32; k++) mem[k] = 8'h40 + 8'(k);
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;

        // Reset values
        repeat (3) tick();
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_sta", o_sta, 0);
        chk("rst_rty", o_rtycnt, 0);
        chk("rst_psh", o_fifopsh, 0);
        chk("rst_wdat", o_wdat, 0);
        chk("rst_first", o_first, 0);
        chk("rst_last", o_last, 0);
        chk("rst_frst", o_fiforst, 0);
        chk("rst_badr", o_badr, 0);
        srst = 1'b0;
        tick();

        // len=4, no stalls, GoodCRC 50 cycles after TX done
        plog.delete(); nfrst = 0;
        i_start = 1'b1; i_len = 5'd4;
        #1 chk("t1_idle_busy", o_busy, 0);
        tick(); i_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t1_psh", o_fifopsh, 1);
            chk("t1_dat", o_wdat, mem[k]);
            chk("t1_first", o_first, (k == 0) ? 1 : 0);
            chk("t1_last", o_last, (k == 3) ? 1 : 0);
            chk("t1_busy", o_busy, 1);
            tick();
        end
        #1 chk("t1_nopsh", o_fifopsh, 0);
        i_txack = 1'b1; tick(); i_txack = 1'b0;
        repeat (20) tick();
        i_start = 1'b1; i_len = 5'd0; tick(); i_start = 1'b0;
        repeat (28) tick();
        #1 chk("t1_busy_wait", o_busy, 1);
        i_gdcrc = 1'b1; tick(); i_gdcrc = 1'b0;
        #1;
        chk("t1_done", o_done, 1);
        chk("t1_sta", o_sta, 0);
        chk("t1_rty", o_rtycnt, 0);
        chk("t1_frst", nfrst, 0);
        chk("t1_npush", plog.size(), 4);
        tick();
        #1;
        chk("t1_done_clr", o_done, 0);
        chk("t1_busy_clr", o_busy, 0);

        // len=3 with a 5-cycle FIFO-full stall after the first push
        plog.delete();
        mem[0] = 8'hA1; mem[1] = 8'hA2; mem[2] = 8'hA3;
        i_start = 1'b1; i_len = 5'd3; tick(); i_start = 1'b0;
        #1;
        chk("t2_psh0", o_fifopsh, 1);
        chk("t2_first0", o_first, 1);
        tick();
        i_fffull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t2_stall_psh", o_fifopsh, 0);
            chk("t2_stall_badr", o_badr, 1);
            tick();
        end
        i_fffull = 1'b0;
        #1;
        chk("t2_dat1", o_wdat, 8'hA2);
        chk("t2_last1", o_last, 0);
        tick();
        #1;
        chk("t2_dat2", o_wdat, 8'hA3);
        chk("t2_last2", o_last, 1);
        tick();
        i_gdcrc = 1'b1; tick(); i_gdcrc = 1'b0;
        #1;
        chk("t2_gdcrc_ign", o_busy, 1);
        i_txack = 1'b1; tick(); i_txack = 1'b0;
        i_gdcrc = 1'b1; tick(); i_gdcrc = 1'b0;
        #1;
        chk("t2_done", o_done, 1);
        chk("t2_sta", o_sta, 0);
        chk("t2_npush", plog.size(), 3);
        chk("t2_log1", plog[1], 8'hA2);
        chk("t2_log2", plog[2], 8'hA3);
        tick();

        // No GoodCRC: three attempts, 900-cycle waits, CC idle gating
        nfrst = 0;
        mem[0] = 8'h5A; mem[1] = 8'hA5;
        i_ccidle = 1'b0;
        i_start = 1'b1; i_len = 5'd2; tick(); i_start = 1'b0;
        for (int a = 0; a < 3; a++) begin
            for (int k = 0; k < 2; k++) begin
                #1;
                chk("t3_psh", o_fifopsh, 1);
                chk("t3_first", o_first, (k == 0) ? 1 : 0);
                chk("t3_dat", o_wdat, mem[k]);
                tick();
            end
            i_txack = 1'b1; tick(); i_txack = 1'b0;
            repeat (899) tick();
            #1;
            chk("t3_wait_frst", o_fiforst, 0);
            chk("t3_wait_done", o_done, 0);
            tick();
            #1;
            if (a < 2) begin
                chk("t3_retry_frst", o_fiforst, 1);
                chk("t3_retry_done", o_done, 0);
                chk("t3_rty_held", o_rtycnt, 0);
                for (int w = 0; w < 3; w++) begin
                    tick();
                    #1;
                    chk("t3_idlewait_psh", o_fifopsh, 0);
                    chk("t3_idlewait_busy", o_busy, 1);
                end
                i_ccidle = 1'b1; tick(); i_ccidle = 1'b0;
            end else begin
                chk("t3_done", o_done, 1);
                chk("t3_sta", o_sta, 1);
                chk("t3_rty", o_rtycnt, 2);
                chk("t3_nfrst", nfrst, 2);
            end
        end
        i_ccidle = 1'b1;
        tick();

        // Abort during LOAD at byte 2, then a new message is accepted
        nfrst = 0;
        i_start = 1'b1; i_len = 5'd5; tick(); i_start = 1'b0;
        tick(); tick();
        #1 chk("t4_badr2", o_badr, 2);
        i_abort = 1'b1; tick(); i_abort = 1'b0;
        #1;
        chk("t4_done", o_done, 1);
        chk("t4_frst", o_fiforst, 1);
        chk("t4_sta", o_sta, 2);
        tick();
        i_start = 1'b1; i_len = 5'd1; tick(); i_start = 1'b0;
        #1;
        chk("t4_new_psh", o_fifopsh, 1);
        chk("t4_new_first", o_first, 1);
        chk("t4_new_last", o_last, 1);
        tick();
        i_txack = 1'b1; tick(); i_txack = 1'b0;
        i_abort = 1'b1; i_gdcrc = 1'b1; tick();
        i_abort = 1'b0; i_gdcrc = 1'b0;
        #1;
        chk("t4_abgd_done", o_done, 1);
        chk("t4_abgd_sta", o_sta, 2);
        chk("t4_abgd_frst", o_fiforst, 1);
        tick();

        // Length errors
        plog.delete();
        i_start = 1'b1; i_len = 5'd31; tick(); i_start = 1'b0;
        #1;
        chk("t5_l31_done", o_done, 1);
        chk("t5_l31_sta", o_sta, 3);
        tick();
        i_start = 1'b1; i_len = 5'd0; tick(); i_start = 1'b0;
        #1;
        chk("t5_l0_done", o_done, 1);
        chk("t5_l0_sta", o_sta, 3);
        chk("t5_l0_rty", o_rtycnt, 0);
        chk("t5_l0_busy", o_busy, 0);
        chk("t5_nopush", plog.size(), 0);
        tick();

        // len=30 and GoodCRC on the exact timeout cycle
        for (int k = 0; k < 32; k++) mem[k] = 8'h40 + 8'(k);
        i_start = 1'b1; i_len = 5'd30; tick(); i_start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            #1;
            chk("t6_psh", o_fifopsh, 1);
            chk("t6_dat", o_wdat, 8'h40 + 8'(k));
            chk("t6_last", o_last, (k == 29) ? 1 : 0);
            tick();
        end
        i_txack = 1'b1; tick(); i_txack = 1'b0;
        repeat (899) tick();
        i_gdcrc = 1'b1; tick(); i_gdcrc = 1'b0;
        #1;
        chk("t6_done", o_done, 1);
        chk("t6_sta", o_sta, 0);
        chk("t6_rty", o_rtycnt, 0);
        chk("t6_frst", o_fiforst, 0);
        tick();

        // Reset mid-operation
        i_start = 1'b1; i_len = 5'd4; tick(); i_start = 1'b0;
        tick();
        srst = 1'b1;
        #1;
        chk("t7_busy", o_busy, 0);
        chk("t7_psh", o_fifopsh, 0);
        chk("t7_badr", o_badr, 0);
        chk("t7_done", o_done, 0);
        chk("t7_frst", o_fiforst, 0);
        tick();
        srst = 1'b0;
        tick();

        // RX activity while waiting for TX done
        i_start = 1'b1; i_len = 5'd1; tick(); i_start = 1'b0;
        tick();
        i_rxact = 1'b1; tick(); i_rxact = 1'b0;
        #1;
`ifdef UPDTXQ_RXABORT_EN
        chk("t8_done", o_done, 1);
        chk("t8_sta", o_sta, 2);
        chk("t8_frst", o_fiforst, 1);
        tick();
`else
        chk("t8_busy", o_busy, 1);
        chk("t8_done", o_done, 0);
        i_txack = 1'b1; tick(); i_txack = 1'b0;
        i_gdcrc = 1'b1; tick(); i_gdcrc = 1'b0;
        #1;
        chk("t8_ok_done", o_done, 1);
        chk("t8_ok_sta", o_sta, 0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/updtxq.md
# updtxq

Transmit message queue and retry controller for the USBPD PHY. Copies one message of 1..MAX_LEN bytes from the host message buffer into the PHY TX FIFO, with first/last framing. After the PHY reports TX done, it waits a bounded time for a matching GoodCRC. On timeout it flushes the FIFO and retransmits, up to RETRY_MAX times, then reports a single completion status to the host. Sits directly upstream of the PHY top: drives its FIFO push/write/first/last/reset inputs and consumes its FIFO ACK, TX-done and CC-idle outputs.

## Interface
- MAX_LEN, 30: maximum message length in bytes; must equal the PHY FIFO depth.
- LEN_NBT, 5: width of length and address fields.
- RETRY_MAX, 2: number of retransmissions after the first attempt.
- CRC_TMO, 900: GoodCRC wait, in clk cycles, counted from TX done.
- TMR_NBT, 10: timer width; must satisfy 2^TMR_NBT > CRC_TMO.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- srst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle request; sampled only in IDLE.
- i_len  in  LEN_NBT  message length; sampled with i_start.
- i_abort  in  1  host abort; honoured in any non-IDLE state.
- o_badr  out  LEN_NBT  host buffer byte address (registered).
- i_bdat  in  8  host buffer data for o_badr; asynchronous read, valid in the same cycle.
- o_busy  out  1  high from i_start acceptance until o_done.
- o_done  out  1  one-cycle completion pulse.
- o_sta  out  2  status, held until next o_done: 0 OK, 1 NOGDCRC, 2 ABORT, 3 ERR.
- o_rtycnt  out  2  retries consumed; held with o_sta.
- o_fifopsh  out  1  FIFO push strobe.
- o_wdat  out  8  FIFO write data.
- o_first  out  1  lock request; high on the first push of each attempt.
- o_last  out  1  high on the final push; triggers the PHY TX request.
- o_fiforst  out  1  one-cycle FIFO flush.
- i_ffack  in  2  FIFO ACK for the previous push: 1 ACK, 2 NAK.
- i_fffull  in  1  FIFO full.
- i_txack  in  1  TX done pulse.
- i_gdcrc  in  1  pulse: GoodCRC received with matching MessageID.
- i_ccidle  in  1  CC line idle.
- i_rxact  in  1  RX has detected a start of packet (used only when the macro is defined).

## Operation
- States: IDLE, LOAD, TXWAIT, CRCWAIT, RETRY, DONE.
- IDLE:
  - i_start with i_len in 1..MAX_LEN → LOAD; o_badr=0, retry count=0.
  - i_len=0 or i_len>MAX_LEN → DONE with sta=3.
- LOAD:
  - Each cycle with ~i_fffull: o_fifopsh=1, o_wdat=i_bdat, o_badr increments.
  - o_first=1 when o_badr==0; o_last=1 when o_badr==len-1.
  - After the last push → TXWAIT.
  - i_fffull stalls the push; address holds.
  - i_ffack==2 → o_fiforst, DONE with sta=3.
- TXWAIT:
  - i_txack → CRCWAIT; timer loads CRC_TMO.
  - i_ffack==2 on the last push → ERR, as in LOAD.
- CRCWAIT:
  - i_gdcrc → DONE with sta=0.
  - Timer reaches 0 with retry count < RETRY_MAX → RETRY; o_fiforst=1; retry count increments.
  - Timer reaches 0 with retry count == RETRY_MAX → DONE with sta=1.
- RETRY: wait for i_ccidle=1, then → LOAD with o_badr=0.
- DONE: o_done=1 for one cycle, o_busy falls, → IDLE.
- Priority within a cycle: i_abort > i_ffack NAK > i_gdcrc > timeout.
- Abort: o_fiforst=1, DONE with sta=2. Also applies when the abort arrives in the same cycle as i_gdcrc.
- i_gdcrc arriving in the same cycle as the timer reaching 0 → success.
- i_gdcrc outside CRCWAIT is ignored.
- i_start while busy is ignored.
- Retry count saturates at RETRY_MAX; o_rtycnt reports the final value.

## Timing
- Reset: all outputs 0; state IDLE; timer 0.
- i_start at cycle N → o_busy and first o_fifopsh at N+1.
- A len-byte message with no stalls pushes on cycles N+1..N+len.
- Timer decrements once per cycle in CRCWAIT; timeout is CRC_TMO cycles after the i_txack cycle.
- o_done follows the deciding event by exactly 1 cycle.
- Reset asserted mid-operation: state and outputs return to the reset values immediately. No o_done and no o_fiforst are emitted.

## Configuration
- UPDTXQ_RXABORT_EN defined: i_rxact=1 in LOAD, TXWAIT or RETRY behaves as i_abort (collision discard): o_fiforst, sta=2.
- Not defined: i_rxact is unused; its presence in the port list is unchanged.

## Structure
- Package updtxq_pkg holds:
  - state enum;
  - status codes STA_OK/NOGDCRC/ABORT/ERR;
  - FIFO ACK codes ACK=1, NAK=2.
- One sub-module, updtxq_tmr: loadable down-counter with zero flag, TMR_NBT wide.

## Test plan
- len=4, bytes 11/22/33/44, no stalls:
  - pushes on 4 consecutive cycles, first on byte 0, last on byte 3;
  - i_txack, then i_gdcrc 50 cycles later → o_sta=0, o_rtycnt=0.
- len=3, i_fffull high 5 cycles after the first push:
  - pushes hold during the stall, data stays in order, last push on 0x…[2];
  - completion status 0.
- No GoodCRC:
  - 3 attempts, each separated by o_fiforst and waiting for i_ccidle;
  - each CRCWAIT lasts exactly 900 cycles;
  - → o_sta=1, o_rtycnt=2.
- i_abort during LOAD at byte 2 → o_fiforst pulse, o_sta=2; a new i_start is then accepted.
- i_len=0 → o_done 1 cycle later, o_sta=3, no pushes.
- Same-cycle i_gdcrc and timer zero → o_sta=0. With UPDTXQ_RXABORT_EN defined, i_rxact in TXWAIT → o_sta=2.
